fdsync_dbuf: RTL and testbench
==============================

Name: fdsync_dbuf

Overview:
Parametrised double-buffered synchronising load register, the next generation of the fixed 32-bit load-enabled register bank.
- Writers load a staging register with per-lane enables.
- The active output `q` updates only on a commit strobe, for example at line or field start, or immediately when immediate mode is selected.
- It tracks a pending-commit flag and a sticky overrun flag.
- It sits between bus-write decode and the video/object pipeline registers.

Parameters:
- WIDTH, 32, total data width in bits; must be a multiple of LANE_W.
- LANE_W, 8, bits per write-enable lane.
- LANES, WIDTH/LANE_W, derived lane count; not to be overridden.
- RESET_VAL, 0, reset value of the staging and active registers, WIDTH bits.

Ports:
- sys_clk  in  1  sole clock; all state is updated on its rising edge.
- resetl  in  1  asynchronous active-low reset.
- d  in  WIDTH  write data; bit 0 is the LSB; lane k is bits k*LANE_W .. k*LANE_W+LANE_W-1.
- be  in  LANES  lane enables for `ld`.
- ld  in  1  write strobe into staging (single-cycle qualified).
- commit  in  1  transfer staging to active.
- imm  in  1  immediate mode: `ld` writes staging and active together.
- clr_ovr  in  1  clears the overrun flag.
- q  out  WIDTH  active register value.
- qs  out  WIDTH  staging register readback.
- pending  out  1  staging holds data not yet committed.
- ovr  out  1  sticky overrun flag.

Behaviour:
- Reset (resetl=0, asynchronous, at any time including mid-write or mid-commit):
  - q = qs = RESET_VAL; pending = 0; ovr = 0.
  - Outputs hold these values until the first sys_clk edge with resetl=1.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.
- Lane merge: merged[k] = be[k] ? d lane k : qs lane k.
  - With ld=1 and be=0, staging is unchanged, but the access still counts as a load for pending and ovr.
- imm=0 (deferred mode), per edge:
  - ld only: qs <= merged; pending <= 1. If pending was already 1, ovr <= 1.
  - commit only, pending=1: q <= qs; pending <= 0.
  - commit only, pending=0: no state change; q holds.
  - ld and commit together: qs <= merged; q <= merged; pending <= 0; no overrun, even if pending was 1.
- imm=1 (immediate mode), per edge:
  - ld: qs <= merged; q <= merged; pending <= 0. If pending was 1 on entry, the stale staging contents are overwritten.
  - commit is ignored; ovr is never set.
- imm is sampled each edge; it may change on any cycle.
  - Switching 0->1 with pending=1 leaves pending=1 until the next ld or commit.
- Latency: q reflects data one sys_clk edge after the ld (imm=1) or commit (imm=0) cycle; qs reflects data one edge after ld.
- ovr:
  - Set and clear are both evaluated per edge.
  - clr_ovr=1 clears it, unless a set condition occurs on the same edge; set wins.
  - Otherwise it holds.
- Elaboration check: WIDTH % LANE_W != 0, or WIDTH < LANE_W, is a fatal error.

Decomposition:
- Package fdsync_pkg holds:
  - the lane-index helper function,
  - the default LANE_W constant,
  - a typedef for the state bundle {pending, ovr}.
- Sub-module fdsync_lane, one instance per lane via generate:
  - holds one staging lane and one active lane;
  - inputs: lane data, lane enable, ld, the shared commit-take signal, imm;
  - no per-lane state beyond these two registers.
- The top level owns pending, ovr and the commit-take decode.

Test Plan:
- Reset with RESET_VAL=32'h1234_5678, then pulse resetl low mid-stream after writes -> q = qs = 32'h1234_5678, pending = 0, ovr = 0, asynchronously, with no clock edge needed.
- imm=0: ld with d=32'hAABB_CCDD, be=4'b0101, then commit -> one edge after ld: qs = 32'h12BB_56DD, q unchanged, pending = 1; one edge after commit: q = 32'h12BB_56DD, pending = 0.
- imm=0: two ld cycles without commit -> ovr = 1 after the second edge. Then:
  - clr_ovr alone clears it;
  - clr_ovr on the same edge as a third ld leaves ovr = 1.
- imm=0, ld and commit on the same cycle with pending = 1 and d = 32'hFFFF_FFFF, be = 4'b1111 -> q = qs = 32'hFFFF_FFFF, pending = 0, ovr unchanged.
- imm=1: ld with d = 32'h0000_00EE, be = 4'b0001 -> q = qs with low byte 8'hEE one edge later; a commit pulse causes no change; ovr stays 0.
- WIDTH=64, LANE_W=16: write be = 4'b1000 with d[63:48] = 16'hBEEF, then commit -> only q[63:48] = 16'hBEEF; all other bits equal RESET_VAL.

Source files
------------

// File: rtl/fdsync_pkg.sv
// Shared constants, types and helpers for the double-buffered sync register.
package fdsync_pkg;

    localparam int unsigned FDSYNC_LANE_W = 8;

    // Top-level control state carried alongside the data lanes.
    typedef struct packed {
        logic pending;
        logic ovr;
    } fdsync_state_t;

    // Bit position of the LSB of a given lane.
    function automatic int lane_lsb(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/fdsync_lane.sv
// One byte-lane slice: a staging register and the active register it feeds.
module fdsync_lane
    import fdsync_pkg::*;
#(
    parameter int unsigned       LANE_W  = FDSYNC_LANE_W,
    parameter logic [LANE_W-1:0] RST_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic [LANE_W-1:0] d_lane,
    input  logic              be_lane,
    input  logic              ld,
    input  logic              take,
    input  logic              imm,
    output logic [LANE_W-1:0] stage_lane,
    output logic [LANE_W-1:0] act_lane
);

    logic [LANE_W-1:0] stage_d, stage_q;
    logic [LANE_W-1:0] act_d, act_q;

    // Merge the write into staging; the active copy takes the merged value on commit or immediate load.
    always_comb begin
        stage_d = stage_q;
        act_d   = act_q;
        if (ld && be_lane) begin
            stage_d = d_lane;
        end
        if (take || (imm && ld)) begin
            act_d = stage_d;
        end
    end

    // Lane registers.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            stage_q <= RST_VAL;
            act_q   <= RST_VAL;
        end else begin
            stage_q <= stage_d;
            act_q   <= act_d;
        end
    end

    assign stage_lane = stage_q;
    assign act_lane   = act_q;

endmodule

// File: rtl/fdsync_dbuf.sv
// Double-buffered, lane-enabled load register with deferred or immediate commit.
module fdsync_dbuf
    import fdsync_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      LANE_W    = FDSYNC_LANE_W,
    parameter int unsigned      LANES     = WIDTH / LANE_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic [WIDTH-1:0] d,
    input  logic [LANES-1:0] be,
    input  logic             ld,
    input  logic             commit,
    input  logic             imm,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qs,
    output logic             pending,
    output logic             ovr
);

    // Reject lane geometries that cannot tile the data word.
    if (((WIDTH % LANE_W) != 0) || (WIDTH < LANE_W)) begin : g_bad_cfg
        $fatal(1, "fdsync_dbuf: WIDTH must be a non-zero multiple of LANE_W");
    end

    fdsync_state_t st_d, st_q;
    logic          commit_take;
    logic          ovr_set;

    // Commit decode plus pending/overrun bookkeeping; set of ovr beats clear.
    always_comb begin
        st_d        = st_q;
        commit_take = commit && !imm && (st_q.pending || ld);
        ovr_set     = !imm && ld && !commit && st_q.pending;

        if (imm) begin
            if (ld) begin
                st_d.pending = 1'b0;
            end
        end else if (ld && commit) begin
            st_d.pending = 1'b0;
        end else if (ld) begin
            st_d.pending = 1'b1;
        end else if (commit) begin
            st_d.pending = 1'b0;
        end

        if (ovr_set) begin
            st_d.ovr = 1'b1;
        end else if (clr_ovr) begin
            st_d.ovr = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        localparam int LSB = lane_lsb(k, int'(LANE_W));

        fdsync_lane #(
            .LANE_W  (LANE_W),
            .RST_VAL (RESET_VAL[LSB +: LANE_W])
        ) u_lane (
            .sys_clk    (sys_clk),
            .resetl     (resetl),
            .d_lane     (d[LSB +: LANE_W]),
            .be_lane    (be[k]),
            .ld         (ld),
            .take       (commit_take),
            .imm        (imm),
            .stage_lane (qs[LSB +: LANE_W]),
            .act_lane   (q[LSB +: LANE_W])
        );
    end

    assign pending = st_q.pending;
    assign ovr     = st_q.ovr;

endmodule

// File: tb/tb_fdsync_dbuf.sv
// Scoreboard bench for fdsync_dbuf: 32-bit/8-bit-lane and 64-bit/16-bit-lane instances.
module tb_fdsync_dbuf;

    localparam logic [31:0] RV_A = 32'h1234_5678;
    localparam logic [63:0] RV_B = 64'h0123_4567_89AB_CDEF;

    logic sys_clk = 1'b0;
    logic resetl  = 1'b0;

    logic [31:0] d_a = '0;
    logic [3:0]  be_a = '0;
    logic        ld_a = 1'b0, commit_a = 1'b0, imm_a = 1'b0, clr_a = 1'b0;
    logic [31:0] q_a, qs_a;
    logic        pend_a, ovr_a;

    logic [63:0] d_b = '0;
    logic [3:0]  be_b = '0;
    logic        ld_b = 1'b0, commit_b = 1'b0, imm_b = 1'b0, clr_b = 1'b0;
    logic [63:0] q_b, qs_b;
    logic        pend_b, ovr_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          dut;
        string       name;
        logic [63:0] q;
        logic [63:0] qs;
        logic        pend;
        logic        ovr;
    } exp_t;

    exp_t sb[$];

    always #5 sys_clk = ~sys_clk;

    fdsync_dbuf #(
        .WIDTH     (32),
        .LANE_W    (8),
        .RESET_VAL (RV_A)
    ) u_dut_a (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .d       (d_a),
        .be      (be_a),
        .ld      (ld_a),
        .commit  (commit_a),
        .imm     (imm_a),
        .clr_ovr (clr_a),
        .q       (q_a),
        .qs      (qs_a),
        .pending (pend_a),
        .ovr     (ovr_a)
    );

    fdsync_dbuf #(
        .WIDTH     (64),
        .LANE_W    (16),
        .RESET_VAL (RV_B)
    ) u_dut_b (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .d       (d_b),
        .be      (be_b),
        .ld      (ld_b),
        .commit  (commit_b),
        .imm     (imm_b),
        .clr_ovr (clr_b),
        .q       (q_b),
        .qs      (qs_b),
        .pending (pend_b),
        .ovr     (ovr_b)
    );

    task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic push(input bit dut, input string nm, input logic [63:0] eq, input logic [63:0] eqs,
                        input logic ep, input logic eo);
        exp_t e;
        e.dut  = dut;
        e.name = nm;
        e.q    = eq;
        e.qs   = eqs;
        e.pend = ep;
        e.ovr  = eo;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents settled registered outputs every falling edge.
    always @(negedge sys_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.dut == 1'b0) begin
                cmp(e.name, "q",       64'(q_a),   e.q);
                cmp(e.name, "qs",      64'(qs_a),  e.qs);
                cmp(e.name, "pending", 64'(pend_a), 64'(e.pend));
                cmp(e.name, "ovr",     64'(ovr_a), 64'(e.ovr));
            end else begin
                cmp(e.name, "q",       q_b,        e.q);
                cmp(e.name, "qs",      qs_b,       e.qs);
                cmp(e.name, "pending", 64'(pend_b), 64'(e.pend));
                cmp(e.name, "ovr",     64'(ovr_b), 64'(e.ovr));
            end
        end
    end

    task automatic step_a(input logic l, input logic c, input logic im, input logic cl,
                          input logic [31:0] dd, input logic [3:0] bb, input string nm,
                          input logic [31:0] eq, input logic [31:0] eqs, input logic ep, input logic eo);
        @(negedge sys_clk);
        #1;
        ld_a = l; commit_a = c; imm_a = im; clr_a = cl; d_a = dd; be_a = bb;
        @(posedge sys_clk);
        push(1'b0, nm, 64'(eq), 64'(eqs), ep, eo);
    endtask

    task automatic step_b(input logic l, input logic c, input logic [63:0] dd, input logic [3:0] bb,
                          input string nm, input logic [63:0] eq, input logic [63:0] eqs, input logic ep);
        @(negedge sys_clk);
        #1;
        ld_b = l; commit_b = c; imm_b = 1'b0; clr_b = 1'b0; d_b = dd; be_b = bb;
        @(posedge sys_clk);
        push(1'b1, nm, eq, eqs, ep, 1'b0);
    endtask

    // Hard bound on total simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Held in reset across a clock edge.
        @(posedge sys_clk);
        push(1'b0, "reset_a", 64'(RV_A), 64'(RV_A), 1'b0, 1'b0);
        @(posedge sys_clk);
        push(1'b1, "reset_b", RV_B, RV_B, 1'b0, 1'b0);
        @(negedge sys_clk);
        #1 resetl = 1'b1;

        //      ld    cm    imm   clr   d              be       name             q              qs             p     o
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'hAABB_CCDD, 4'b0101, "ld_lanes",      RV_A,          32'h12BB_56DD, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         4'b0000, "commit",        32'h12BB_56DD, 32'h12BB_56DD, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h1111_1111, 4'b1111, "ld_full",       32'h12BB_56DD, 32'h1111_1111, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_2222, 4'b0011, "ld_overrun",    32'h12BB_56DD, 32'h1111_2222, 1'b1, 1'b1);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, "clr_ovr",       32'h12BB_56DD, 32'h1111_2222, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 4'b1000, "set_beats_clr", 32'h12BB_56DD, 32'h3311_2222, 1'b1, 1'b1);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1111, "ld_commit",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         4'b0000, "clr_ovr2",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         4'b0000, "commit_idle",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00EE, 4'b0001, "imm_ld",        32'hFFFF_FFEE, 32'hFFFF_FFEE, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         4'b0000, "imm_commit",    32'hFFFF_FFEE, 32'hFFFF_FFEE, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         4'b0000, "ld_be0",        32'hFFFF_FFEE, 32'hFFFF_FFEE, 1'b1, 1'b0);
        step_a(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'b0000, "imm_switch",    32'hFFFF_FFEE, 32'hFFFF_FFEE, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0055_0000, 4'b0100, "imm_over_pend", 32'hFF55_FFEE, 32'hFF55_FFEE, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 4'b0001, "ld_after_imm",  32'hFF55_FFEE, 32'hFF55_FF01, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1111, "ld_overrun2",   32'hFF55_FFEE, 32'hDEAD_BEEF, 1'b1, 1'b1);

        // Asynchronous reset mid-write: asserted after a rising edge, checked before the next one.
        @(posedge sys_clk);
        #2 resetl = 1'b0;
        push(1'b0, "async_reset", 64'(RV_A), 64'(RV_A), 1'b0, 1'b0);
        @(negedge sys_clk);
        #1;
        ld_a = 1'b0; commit_a = 1'b0; clr_a = 1'b0; be_a = '0; d_a = '0;
        @(posedge sys_clk);
        push(1'b0, "reset_hold", 64'(RV_A), 64'(RV_A), 1'b0, 1'b0);
        @(negedge sys_clk);
        #1 resetl = 1'b1;
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, "post_reset", RV_A, RV_A, 1'b0, 1'b0);

        // Wide instance: only the top 16-bit lane is written.
        step_b(1'b1, 1'b0, 64'hBEEF_1111_2222_3333, 4'b1000, "wide_ld",     RV_B, 64'hBEEF_4567_89AB_CDEF, 1'b1);
        step_b(1'b0, 1'b1, 64'h0,                   4'b0000, "wide_commit", 64'hBEEF_4567_89AB_CDEF, 64'hBEEF_4567_89AB_CDEF, 1'b0);

        // Drain: every expectation must have been consumed within a bounded number of cycles.
        repeat (3) @(posedge sys_clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
